// File: rtl/filter_sp_write_controller_pkg.sv
// filter_sp_write_controller_pkg: shared state encoding, default sizes and width helper
package filter_sp_write_controller_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_SPACE, DONE} state_t;
   localparam int SP_SIZE_DEF              = 8;
   localparam int FILTER_SIZE_REG_SIZE_DEF = 8;
   localparam int POINTER_SIZE_DEF         = 8;
   localparam int DATA_WIDTH_DEF           = 16;
   function automatic int free_width(input int sp_size);
      return $clog2(sp_size + 1);
   endfunction
endpackage

// File: rtl/filter_sp_write_controller_if.sv
// filter_sp_write_controller_if: FWFT FIFO read port and scratchpad write port
interface filter_sp_write_controller_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int POINTER_SIZE = 8
);
   logic                    fifo_empty;
   logic [DATA_WIDTH-1:0]   fifo_rdata;
   logic                    fifo_ren;
   logic                    sp_wen;
   logic [POINTER_SIZE-1:0] sp_waddr;
   logic [DATA_WIDTH-1:0]   sp_wdata;
   modport master (input fifo_empty, fifo_rdata, output fifo_ren, sp_wen, sp_waddr, sp_wdata);
   modport slave (output fifo_empty, fifo_rdata, input fifo_ren, sp_wen, sp_waddr, sp_wdata);
endinterface

// File: rtl/filter_sp_write_controller_sp_occupancy_tracker.sv
// filter_sp_write_controller_sp_occupancy_tracker: free word and resident filter accounting
module filter_sp_write_controller_sp_occupancy_tracker #(
   parameter int SP_SIZE = 8,
   parameter int FS_W    = 8,
   parameter int FREE_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic              complete,
   input  logic              released,
   input  logic [FS_W-1:0]   fs,
   output logic [FREE_W-1:0] free_words,
   output logic [FREE_W-1:0] resident_cnt
);
   logic rel;
   assign rel = released && resident_cnt != '0;
   // a write and an honoured release in the same cycle both apply
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_words   <= FREE_W'(SP_SIZE);
         resident_cnt <= '0;
      end else begin
         free_words   <= free_words - FREE_W'(wr) + (rel ? FREE_W'(fs) : '0);
         resident_cnt <= resident_cnt + FREE_W'(complete) - FREE_W'(rel);
      end
   end
endmodule

// File: rtl/filter_sp_write_controller.sv
// filter_sp_write_controller: pops filter words from an FWFT FIFO into the circular filter scratchpad
module filter_sp_write_controller
   import filter_sp_write_controller_pkg::*;
#(
   parameter int SP_SIZE              = SP_SIZE_DEF,
   parameter int FILTER_SIZE_REG_SIZE = FILTER_SIZE_REG_SIZE_DEF,
   parameter int POINTER_SIZE         = POINTER_SIZE_DEF,
   parameter int DATA_WIDTH           = DATA_WIDTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [FILTER_SIZE_REG_SIZE-1:0]   filter_size,
   input  logic [FILTER_SIZE_REG_SIZE-1:0]   num_filters,
   filter_sp_write_controller_if.master      bus,
   input  logic                              filter_released,
   output logic                              filter_ready,
   output logic [$clog2(SP_SIZE+1)-1:0]      resident_cnt,
   output logic                              busy,
   output logic                              done,
   output logic                              cfg_err
);
   localparam int FS_W   = FILTER_SIZE_REG_SIZE;
   localparam int FREE_W = free_width(SP_SIZE);
   localparam int PTR_W  = SP_SIZE > 1 ? $clog2(SP_SIZE) : 1;
   state_t            state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [FS_W-1:0]   word_cnt, loaded_cnt, fs_r, nf_r;
   logic [FREE_W-1:0] free_words;
   logic              wr, last_word, fs_ok;
   assign wr            = state == LOAD && !bus.fifo_empty && free_words != '0;
   assign last_word     = word_cnt == fs_r - FS_W'(1);
   assign fs_ok         = filter_size != '0 && filter_size <= FS_W'(SP_SIZE);
   assign bus.fifo_ren  = wr;
   assign bus.sp_wen    = wr;
   assign bus.sp_waddr  = POINTER_SIZE'(wr_ptr);
   assign bus.sp_wdata  = wr ? bus.fifo_rdata : DATA_WIDTH'(0);
   assign filter_ready  = resident_cnt != '0;
   filter_sp_write_controller_sp_occupancy_tracker #(
      .SP_SIZE (SP_SIZE),
      .FS_W    (FS_W),
      .FREE_W  (FREE_W)
   ) u_occ (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr),
      .complete     (wr && last_word),
      .released     (filter_released),
      .fs           (fs_r),
      .free_words   (free_words),
      .resident_cnt (resident_cnt)
   );
   // load FSM with write pointer, in-filter word count and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         word_cnt   <= '0;
         loaded_cnt <= '0;
         fs_r       <= '0;
         nf_r       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr     <= wr_ptr == PTR_W'(SP_SIZE - 1) ? '0 : wr_ptr + PTR_W'(1);
            word_cnt   <= last_word ? '0 : word_cnt + FS_W'(1);
            loaded_cnt <= loaded_cnt + FS_W'(last_word);
         end
         case (state)
            IDLE, DONE: if (start) begin
               if (!fs_ok) cfg_err <= 1'b1;
               else begin
                  cfg_err    <= 1'b0;
                  fs_r       <= filter_size;
                  nf_r       <= num_filters;
                  word_cnt   <= '0;
                  loaded_cnt <= '0;
                  done       <= num_filters == '0;
                  busy       <= num_filters != '0;
                  state      <= num_filters == '0 ? IDLE : LOAD;
               end
            end
            LOAD: if (wr && last_word && loaded_cnt == nf_r - FS_W'(1)) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else if (free_words == '0) state <= WAIT_SPACE;
            WAIT_SPACE: if (free_words != '0) state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_filter_sp_write_controller.sv
// tb_filter_sp_write_controller: scoreboard bench for the filter scratchpad write controller
module tb_filter_sp_write_controller;
   import filter_sp_write_controller_pkg::*;
   localparam int SP = 8, FW = 8, PS = 8, DW = 16;
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, filter_released = 1'b0;
   logic [FW-1:0] filter_size = '0, num_filters = '0;
   logic          filter_ready, busy, done, cfg_err;
   logic [3:0]    resident_cnt;
   filter_sp_write_controller_if #(.DATA_WIDTH(DW), .POINTER_SIZE(PS)) bus ();
   filter_sp_write_controller #(
      .SP_SIZE (SP), .FILTER_SIZE_REG_SIZE (FW), .POINTER_SIZE (PS), .DATA_WIDTH (DW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .filter_size     (filter_size),
      .num_filters     (num_filters),
      .bus             (bus.master),
      .filter_released (filter_released),
      .filter_ready    (filter_ready),
      .resident_cnt    (resident_cnt),
      .busy            (busy),
      .done            (done),
      .cfg_err         (cfg_err)
   );
   always #5 clk = ~clk;
   int            total = 0, bad = 0;
   logic [DW-1:0] fifo_q[$], exp_d[$];
   int            exp_a[$];
   bit            hold = 1'b0, pop_pending = 1'b0;
   // model: next address, occupied words, resident filters, current filter size, words of this set
   int            m_ptr = 0, m_occ = 0, m_res = 0, m_fs = 0, m_words = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: scoreboard for writes plus occupancy model advanced through each edge
   always @(negedge clk) begin
      if (!rst) begin
         pop_pending = bus.sp_wen;
         check("resident_cnt", 32'(resident_cnt), 32'(m_res));
         check("filter_ready", 32'(filter_ready), 32'(m_res != 0));
         check("free_words", 32'(dut.free_words), 32'(SP - m_occ));
         check("ren_eq_wen", 32'(bus.fifo_ren), 32'(bus.sp_wen));
         if (bus.sp_wen) begin
            check("no_overflow", 32'(m_occ < SP), 32'd1);
            if (exp_a.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr %0d data %0h", bus.sp_waddr, bus.sp_wdata);
            end else begin
               check("waddr", 32'(bus.sp_waddr), 32'(exp_a.pop_front()));
               check("wdata", 32'(bus.sp_wdata), 32'(exp_d.pop_front()));
            end
         end
         if (filter_released && m_res != 0) begin
            m_res--;
            m_occ -= m_fs;
         end
         if (bus.sp_wen) begin
            m_occ++;
            m_words++;
            if (m_words % m_fs == 0) m_res++;
         end
      end
   end
   task automatic drive_fifo();
      bus.fifo_empty = hold || fifo_q.size() == 0;
      bus.fifo_rdata = fifo_q.size() != 0 ? fifo_q[0] : '0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      if (pop_pending) begin
         pop_pending = 1'b0;
         void'(fifo_q.pop_front());
      end
      drive_fifo();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      filter_released = 1'b0;
      hold = 1'b0;
      pop_pending = 1'b0;
      fifo_q.delete();
      exp_a.delete();
      exp_d.delete();
      m_ptr = 0; m_occ = 0; m_res = 0; m_fs = 0; m_words = 0;
      drive_fifo();
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic outputs_zero();
      check("z_fifo_ren", 32'(bus.fifo_ren), 0);
      check("z_sp_wen", 32'(bus.sp_wen), 0);
      check("z_sp_waddr", 32'(bus.sp_waddr), 0);
      check("z_sp_wdata", 32'(bus.sp_wdata), 0);
      check("z_filter_ready", 32'(filter_ready), 0);
      check("z_resident_cnt", 32'(resident_cnt), 0);
      check("z_busy", 32'(busy), 0);
      check("z_done", 32'(done), 0);
      check("z_cfg_err", 32'(cfg_err), 0);
   endtask
   task automatic start_cfg(input int fs, input int nf);
      bit ok;
      ok = fs >= 1 && fs <= SP;
      filter_released = 1'b0;
      start = 1'b1;
      filter_size = FW'(fs);
      num_filters = FW'(nf);
      if (ok) begin
         m_fs = fs;
         m_words = 0;
      end
      tick();
      start = 1'b0;
      check("cfg_err", 32'(cfg_err), 32'(!ok));
      check("busy_after_start", 32'(busy), 32'(ok && nf != 0));
      if (ok) check("done_after_start", 32'(done), 32'(nf == 0));
   endtask
   task automatic push_words(input int n);
      logic [DW-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = DW'($urandom);
         fifo_q.push_back(d);
         exp_d.push_back(d);
         exp_a.push_back(m_ptr);
         m_ptr = (m_ptr + 1) % SP;
      end
      drive_fifo();
   endtask
   task automatic wait_left(input int n, input int budget);
      for (int i = 0; i < budget && exp_a.size() > n; i++) tick();
      check("writes_left", 32'(exp_a.size()), 32'(n));
   endtask
   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) tick();
      check("done", 32'(done), 1);
      check("all_written", 32'(exp_a.size()), 0);
      check("busy_at_done", 32'(busy), 0);
   endtask
   task automatic release_pulse();
      filter_released = 1'b1;
      tick();
      filter_released = 1'b0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int fs, nf;
      drive_fifo();
      // basic load, no releases
      do_reset();
      outputs_zero();
      start_cfg(3, 2);
      push_words(6);
      wait_done(40);
      check("t1_resident", 32'(resident_cnt), 2);
      // scratchpad fills, waits for one release
      do_reset();
      start_cfg(4, 3);
      push_words(12);
      wait_left(4, 30);
      tick();
      tick();
      check("t2_busy", 32'(busy), 1);
      check("t2_fifo_ren", 32'(bus.fifo_ren), 0);
      check("t2_wait_space", 32'(dut.state == WAIT_SPACE), 1);
      release_pulse();
      wait_done(40);
      // FIFO starves mid-filter
      do_reset();
      start_cfg(3, 2);
      push_words(1);
      wait_left(0, 10);
      hold = 1'b1;
      push_words(5);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_no_wen", 32'(bus.sp_wen), 0);
         check("t3_word_cnt", 32'(dut.word_cnt), 1);
      end
      hold = 1'b0;
      drive_fifo();
      wait_done(40);
      // last free word written in the same cycle as a release
      do_reset();
      start_cfg(4, 3);
      push_words(7);
      wait_left(0, 20);
      filter_released = 1'b1;
      push_words(1);
      tick();
      filter_released = 1'b0;
      check("t4_free", 32'(dut.free_words), 4);
      check("t4_resident", 32'(resident_cnt), 1);
      check("t4_load", 32'(dut.state == LOAD), 1);
      push_words(4);
      wait_done(40);
      // configuration errors
      do_reset();
      start_cfg(0, 1);
      start_cfg(9, 1);
      start_cfg(2, 1);
      push_words(2);
      wait_done(20);
      start_cfg(3, 0);
      // asynchronous reset mid-load
      do_reset();
      start_cfg(4, 2);
      push_words(8);
      wait_left(3, 20);
      check("t6_wr_ptr", 32'(dut.wr_ptr), 5);
      #2 rst = 1'b1;
      #1 outputs_zero();
      do_reset();
      start_cfg(2, 1);
      release_pulse();
      push_words(2);
      wait_done(20);
      // randomized filter sets with random FIFO gaps and releases
      do_reset();
      for (int s = 0; s < 6; s++) begin
         fs = $urandom_range(1, SP);
         nf = $urandom_range(1, 4);
         start_cfg(fs, nf);
         push_words(fs * nf);
         for (int i = 0; i < 400 && !done; i++) begin
            hold = $urandom_range(0, 3) == 0;
            filter_released = $urandom_range(0, 2) == 0;
            drive_fifo();
            tick();
         end
         hold = 1'b0;
         filter_released = 1'b0;
         drive_fifo();
         check("rnd_done", 32'(done), 1);
         check("rnd_all_written", 32'(exp_a.size()), 0);
         for (int i = 0; i < 20 && m_res != 0; i++) begin
            release_pulse();
            tick();
         end
         check("rnd_drained", 32'(resident_cnt), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
